// File: rtl/store_drain_buffer.sv
// Retire-side store drain buffer: queues committed stores in order and writes them to
// data memory one at a time over a req/ack handshake, with byte strobes and lane-aligned data.
// Optional load forwarding CAM enabled by defining STORE_FWD_EN; otherwise loads stall until drained.
module store_drain_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          commit_valid_i,
    output logic                          commit_ready_o,
    input  logic [ADDR_WIDTH-1:0]         commit_addr_i,
    input  logic [DATA_WIDTH-1:0]         commit_data_i,
    input  logic [2:0]                    commit_funct3_i,
    output logic                          mem_req_o,
    input  logic                          mem_ack_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb_o,
    input  logic [ADDR_WIDTH-1:0]         ld_addr_i,
    output logic                          fwd_hit_o,
    output logic [DATA_WIDTH-1:0]         fwd_data_o,
    output logic                          fwd_stall_o,
    output logic                          sb_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   sb_count_o
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;

    // Entries hold the word address plus already lane-aligned data/strobes.
    logic [ADDR_WIDTH-1:0] ent_addr_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_wdata_q [FIFO_DEPTH];
    logic [StrbW-1:0]      ent_wstrb_q [FIFO_DEPTH];
    logic                  ent_word_q  [FIFO_DEPTH];

    logic                  full, push, pop;
    logic [DATA_WIDTH-1:0] push_wdata;
    logic [StrbW-1:0]      push_wstrb;
    logic                  push_word;

    assign full = (count_q == CntW'(FIFO_DEPTH));
    assign push = commit_valid_i && !full;
    assign pop  = (state_q == StIssue) && mem_ack_i;

    // Lane alignment of the incoming store by funct3 and low address bits.
    always_comb begin
        push_wstrb = '1;
        push_wdata = commit_data_i;
        push_word  = 1'b1;
        case (commit_funct3_i)
            3'b000: begin
                push_wstrb = StrbW'(1) << commit_addr_i[1:0];
                push_wdata = DATA_WIDTH'(commit_data_i[7:0]) << {commit_addr_i[1:0], 3'b000};
                push_word  = 1'b0;
            end
            3'b001: begin
                push_wstrb = StrbW'(2'b11) << {commit_addr_i[1], 1'b0};
                push_wdata = DATA_WIDTH'(commit_data_i[15:0]) << {commit_addr_i[1], 4'b0000};
                push_word  = 1'b0;
            end
            default: ;
        endcase
    end

    // Entry storage write on push; contents only matter while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr_q[tail_q]  <= {commit_addr_i[ADDR_WIDTH-1:2], 2'b00};
            ent_wdata_q[tail_q] <= push_wdata;
            ent_wstrb_q[tail_q] <= push_wstrb;
            ent_word_q[tail_q]  <= push_word;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Drain FSM next state: stay in issue back-to-back while more than one entry remains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StIssue;
            end
            StIssue: begin
                if (mem_ack_i && count_q <= CntW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Drain FSM outputs: head entry presented only while a request is active.
    always_comb begin
        mem_req_o   = (state_q == StIssue);
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (mem_req_o) begin
            mem_addr_o  = ent_addr_q[head_q];
            mem_wdata_o = ent_wdata_q[head_q];
            mem_wstrb_o = ent_wstrb_q[head_q];
        end
    end

    assign commit_ready_o = !full;
    assign sb_empty_o     = (count_q == '0) && (state_q == StIdle);
    assign sb_count_o     = count_q;

`ifdef STORE_FWD_EN
    logic [PtrW-1:0] fwd_idx;
    logic            unused_ld_lsb;

    assign unused_ld_lsb = ^ld_addr_i[1:0];

    // Scan oldest to youngest so the youngest matching valid entry decides.
    always_comb begin
        fwd_hit_o   = 1'b0;
        fwd_stall_o = 1'b0;
        fwd_data_o  = '0;
        fwd_idx     = '0;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            fwd_idx = head_q + PtrW'(k);
            if ((CntW'(k) < count_q) &&
                (ent_addr_q[fwd_idx][ADDR_WIDTH-1:2] == ld_addr_i[ADDR_WIDTH-1:2])) begin
                fwd_hit_o   = ent_word_q[fwd_idx];
                fwd_stall_o = !ent_word_q[fwd_idx];
                fwd_data_o  = ent_word_q[fwd_idx] ? ent_wdata_q[fwd_idx] : '0;
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld   = ^ld_addr_i;
    // Without forwarding, any buffered or in-flight store holds off loads.
    assign fwd_hit_o   = 1'b0;
    assign fwd_data_o  = '0;
    assign fwd_stall_o = !sb_empty_o;
`endif

endmodule
